hweval_run_ctrl: RTL and testbench
==================================

# hweval_run_ctrl

Run controller for the hardware-evaluation harness around the 256-bit doubling datapath. It latches two seeds and a run length, and loads the seeds into the two operand LFSRs through a local reset. It waits out the datapath pipeline, then compresses `comp_out` into a 32-bit MISR signature over a programmed number of cycles. A single-cycle `done` marks the end of a run; `busy`, `done` and the final signature are what the board-level test host observes.

## Interface
Parameters:
- `SEED_W`, 16, LFSR seed width
- `OUT_W`, 10, width of datapath `comp_out`
- `CNT_W`, 16, run-length counter width
- `PIPE_LAT`, 4, cycles from LFSR release until the first valid `comp_out`; must be ≥1
- `SIG_W`, 32, MISR signature width

Ports:
- `clk` input 1: single clock.
- `resetn` input 1: reset is asynchronous and active-low.
- `start` input 1: run request, sampled only in IDLE.
- `abort` input 1: cancels a run in progress.
- `seed0`, `seed1` input SEED_W: run seeds, latched on an accepted `start`.
- `run_len` input CNT_W: number of `comp_out` samples, latched on an accepted `start`.
- `comp_out` input OUT_W: datapath result.
- `dut_resetn` output 1: local reset to the LFSRs and datapath.
- `lfsr_seed0`, `lfsr_seed1` output SEED_W: LFSR `in_init` values.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse at normal completion.
- `aborted` output 1: sticky flag, last run was aborted.
- `signature` output SIG_W: MISR value.
- `sample_cnt` output CNT_W: samples taken in the current or last run.

## Operation
- FSM states: IDLE, LOAD, FILL, RUN, DONE.
- **IDLE → LOAD** on `start`.
  - Latch seeds and `run_len`.
  - Clear `signature`, `sample_cnt` and `aborted`.
  - `start` in any other state is ignored.
- **Seed substitution:** a latched seed equal to 0 is replaced by `DEFAULT_SEED` (16'hACE1), because a zero seed would lock the LFSR.
- **LOAD:** lasts exactly one cycle with `dut_resetn` = 0. Then go to FILL.
- **FILL:** lasts `PIPE_LAT` cycles and takes no samples. Then go to RUN, or go straight to DONE if the latched `run_len` = 0.
- **RUN:** takes one sample per cycle for `run_len` cycles. Each cycle:
  - `signature` ← (`signature` << 1) ^ (`signature`[SIG_W-1] ? `MISR_POLY` : 0) ^ zero-extended `comp_out`.
  - `sample_cnt` increments.
  - Leave for DONE after the sample where `sample_cnt` reaches `run_len`.
- **DONE:** one cycle with `done` = 1, then return to IDLE.
- **`signature` / `sample_cnt` hold:** both keep their values in IDLE until the next accepted `start`.
- **`abort`:** in LOAD, FILL or RUN, go to IDLE on the next edge.
  - Set `aborted`; no `done` pulse.
  - `signature` and `sample_cnt` keep their partial values.
  - A RUN-cycle sample coincident with `abort` is still taken.
- **`abort` and `start` together in IDLE:** `start` wins; `abort` is ignored in IDLE and DONE.
- **Counter width:** `sample_cnt` never wraps; `run_len` up to 2^CNT_W−1 is legal.
- **`lfsr_seed0/1`:** always present the latched (substituted) seeds; they hold across runs.

## Timing
- Reset values:
  - Asynchronous on `resetn` low: state IDLE, `dut_resetn` = 0, `busy` = 0, `done` = 0, `aborted` = 0, `signature` = 0, `sample_cnt` = 0, `lfsr_seed0/1` = `DEFAULT_SEED`.
  - First edge after reset release: `dut_resetn` = 1.
- All outputs are registered. `dut_resetn` is a flop decoded from next state, so it is glitch-free and low exactly during the LOAD cycle.
- With `start` sampled at edge T:
  - LOAD is cycle T+1.
  - FILL is T+2 … T+1+PIPE_LAT.
  - RUN samples are at T+2+PIPE_LAT … T+1+PIPE_LAT+run_len.
  - `done` is high in cycle T+2+PIPE_LAT+run_len.
- `busy` = 1 in LOAD, FILL and RUN; 0 in IDLE and DONE.
- The earliest next `start` is accepted in the cycle after DONE.
- The final `signature` is valid in the same cycle `done` is high.

## Structure
- Package `hweval_pkg` holds:
  - `run_state_t` enum (IDLE, LOAD, FILL, RUN, DONE).
  - `MISR_POLY` = 32'h04C11DB7.
  - `DEFAULT_SEED` = 16'hACE1.
- Sub-module `hweval_misr` (SIG_W, OUT_W): `clr`, `en`, `din`, `sig`. It holds the compression register only.
- Top level: FSM, FILL/RUN counter, seed latch and substitution, output flops.

## Test plan
- `run_len` = 0, PIPE_LAT = 4, `start` at T → `dut_resetn` low at T+1 only; `done` at T+6; `signature` = 0; `sample_cnt` = 0.
- `comp_out` = 1 for 2 samples (`run_len` = 2) → `signature` = 32'h3, `done` at T+8; `run_len` = 1 with `comp_out` = 10'h3FF → `signature` = 32'h3FF.
- `comp_out` = 1 for 33 samples → the bit-31 feedback term `MISR_POLY` is applied on the 33rd shift; `signature` is checked against the reference-model value.
- `seed0` = 0, `seed1` = 16'h1234 → `lfsr_seed0` = 16'hACE1, `lfsr_seed1` = 16'h1234 at T+1.
- `abort` in the 3rd RUN cycle with `run_len` = 10 → IDLE next cycle; `aborted` = 1; `sample_cnt` = 3; no `done`.
- `start` pulsed during FILL and during DONE → ignored; `resetn` low mid-RUN → all outputs return to reset values immediately.

Source files
------------

// File: rtl/hweval_pkg.sv
// Shared types and constants for the hardware-evaluation run controller.
// Imported by the run controller and its MISR.
package hweval_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } run_state_t;

  localparam logic [31:0] MISR_POLY    = 32'h04C11DB7;
  // A zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/hweval_run_ctrl_if.sv
// Host/datapath bundle for the run controller.
// The slave modport is the controller side; master is the host/harness side.
interface hweval_run_ctrl_if #(
  parameter int unsigned SEED_W = 16,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SIG_W  = 32
);
  logic              start;
  logic              abort;
  logic [SEED_W-1:0] seed0;
  logic [SEED_W-1:0] seed1;
  logic [CNT_W-1:0]  run_len;
  logic [OUT_W-1:0]  comp_out;
  logic              dut_resetn;
  logic [SEED_W-1:0] lfsr_seed0;
  logic [SEED_W-1:0] lfsr_seed1;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  sample_cnt;

  modport slave (
    input  start, abort, seed0, seed1, run_len, comp_out,
    output dut_resetn, lfsr_seed0, lfsr_seed1, busy, done, aborted, signature, sample_cnt
  );

  modport master (
    output start, abort, seed0, seed1, run_len, comp_out,
    input  dut_resetn, lfsr_seed0, lfsr_seed1, busy, done, aborted, signature, sample_cnt
  );
endinterface

// File: rtl/hweval_misr.sv
// 32-bit style MISR compressing the datapath output into a signature.
// Holds only the compression register; sequencing lives in the controller.
module hweval_misr
  import hweval_pkg::*;
#(
  parameter int unsigned SIG_W = 32,
  parameter int unsigned OUT_W = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_nxt;

  always_comb begin
    w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
              ^ (r_sig[SIG_W-1] ? SIG_W'(MISR_POLY) : '0)
              ^ SIG_W'(din);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= w_sig_nxt;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/hweval_run_ctrl.sv
// Run controller: latches seeds, pulses the local datapath reset, waits out
// the pipeline, then compresses comp_out into a MISR signature.
module hweval_run_ctrl
  import hweval_pkg::*;
#(
  parameter int unsigned SEED_W   = 16,
  parameter int unsigned OUT_W    = 10,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned SIG_W    = 32
) (
  input logic              clk,
  input logic              resetn,
  hweval_run_ctrl_if.slave bus
);

  localparam int unsigned FillW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;

  run_state_t        r_state;
  run_state_t        w_state_nxt;
  logic [FillW-1:0]  r_fill_cnt;
  logic [CNT_W-1:0]  r_run_len;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [SEED_W-1:0] r_seed0;
  logic [SEED_W-1:0] r_seed1;
  logic              r_dut_resetn;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic              w_start_ok;
  logic              w_abort_ok;
  logic              w_fill_last;
  logic              w_run_last;
  logic              w_sample;

  assign w_start_ok  = (r_state == IDLE) && bus.start;
  assign w_abort_ok  = bus.abort && (r_state inside {LOAD, FILL, RUN});
  assign w_fill_last = (r_fill_cnt == FillW'(PIPE_LAT - 1));
  // run_len never exceeds 2^CNT_W-1, so the incremented count cannot wrap here.
  assign w_run_last  = ((r_sample_cnt + CNT_W'(1)) == r_run_len);
  assign w_sample    = (r_state == RUN);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (bus.start) w_state_nxt = LOAD;
      LOAD: w_state_nxt = FILL;
      FILL: if (w_fill_last) w_state_nxt = (r_run_len == '0) ? DONE : RUN;
      RUN:  if (w_run_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort_ok) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_fill_cnt   <= '0;
      r_run_len    <= '0;
      r_sample_cnt <= '0;
      r_seed0      <= SEED_W'(DEFAULT_SEED);
      r_seed1      <= SEED_W'(DEFAULT_SEED);
      r_dut_resetn <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Decoded from next state so the local reset is a clean flop output.
      r_dut_resetn <= (w_state_nxt != LOAD);
      r_busy       <= (w_state_nxt inside {LOAD, FILL, RUN});
      r_done       <= (w_state_nxt == DONE);
      r_fill_cnt   <= (r_state == FILL) ? r_fill_cnt + FillW'(1) : '0;

      if (w_start_ok) begin
        r_run_len    <= bus.run_len;
        r_seed0      <= (bus.seed0 == '0) ? SEED_W'(DEFAULT_SEED) : bus.seed0;
        r_seed1      <= (bus.seed1 == '0) ? SEED_W'(DEFAULT_SEED) : bus.seed1;
        r_sample_cnt <= '0;
        r_aborted    <= 1'b0;
      end else begin
        if (w_sample) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        if (w_abort_ok) r_aborted <= 1'b1;
      end
    end
  end

  logic [SIG_W-1:0] w_sig;

  hweval_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W)
  ) u_misr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (w_start_ok),
    .en     (w_sample),
    .din    (bus.comp_out),
    .sig    (w_sig)
  );

  assign bus.dut_resetn = r_dut_resetn;
  assign bus.lfsr_seed0 = r_seed0;
  assign bus.lfsr_seed1 = r_seed1;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.aborted    = r_aborted;
  assign bus.signature  = w_sig;
  assign bus.sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_hweval_run_ctrl.sv
// Bench for hweval_run_ctrl: directed and random runs against a cycle-indexed
// reference model of the run timeline and a queue-folded signature.
module tb_hweval_run_ctrl;
  import hweval_pkg::*;

  localparam int P = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  hweval_run_ctrl_if bus ();

  hweval_run_ctrl #(
    .PIPE_LAT (P)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  logic [15:0] exp_seed0 = 16'hACE1;
  logic [15:0] exp_seed1 = 16'hACE1;
  logic [9:0]  samples[$];
  bit          exp_aborted = 1'b0;

  // Signature defined as the fold of every accepted sample through the MISR rule.
  function automatic logic [31:0] sig_of();
    logic [31:0] s = 32'h0;
    foreach (samples[i]) begin
      s = (s << 1) ^ (s[31] ? MISR_POLY : 32'h0) ^ {22'h0, samples[i]};
    end
    return s;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_dut_resetn"}, 64'(bus.dut_resetn), 64'(0));
    check({tag, "_busy"},       64'(bus.busy),       64'(0));
    check({tag, "_done"},       64'(bus.done),       64'(0));
    check({tag, "_aborted"},    64'(bus.aborted),    64'(0));
    check({tag, "_signature"},  64'(bus.signature),  64'(0));
    check({tag, "_sample_cnt"}, 64'(bus.sample_cnt), 64'(0));
    check({tag, "_seed0"},      64'(bus.lfsr_seed0), 64'(16'hACE1));
    check({tag, "_seed1"},      64'(bus.lfsr_seed1), 64'(16'hACE1));
  endtask

  // c counts cycles after the accepting edge T: cycle 1 is LOAD.
  // ab_c = 0 means no abort; otherwise abort is driven during cycle ab_c.
  task automatic do_run(input logic [15:0] s0, input logic [15:0] s1, input int len,
                        input int ab_c, input bit poke, input bit fixed,
                        input logic [9:0] val);
    int  c_rs, c_re, c_done;
    bit  after_ab;
    c_rs   = P + 2;
    c_re   = P + 1 + len;
    c_done = P + 2 + len;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.seed0   = s0;
    bus.seed1   = s1;
    bus.run_len = 16'(len);
    @(negedge clk);
    bus.start = 1'b0;
    samples.delete();
    exp_seed0   = (s0 == 16'h0) ? 16'hACE1 : s0;
    exp_seed1   = (s1 == 16'h0) ? 16'hACE1 : s1;
    exp_aborted = 1'b0;
    for (int c = 1; c <= c_done + 1; c++) begin
      after_ab = (ab_c != 0) && (c > ab_c);
      if (after_ab) exp_aborted = 1'b1;
      check("dut_resetn", 64'(bus.dut_resetn), 64'(c != 1));
      check("busy",       64'(bus.busy),       64'(!after_ab && c <= c_re));
      check("done",       64'(bus.done),       64'(ab_c == 0 && c == c_done));
      check("aborted",    64'(bus.aborted),    64'(exp_aborted));
      check("sample_cnt", 64'(bus.sample_cnt), 64'(samples.size()));
      check("signature",  64'(bus.signature),  64'(sig_of()));
      check("lfsr_seed0", 64'(bus.lfsr_seed0), 64'(exp_seed0));
      check("lfsr_seed1", 64'(bus.lfsr_seed1), 64'(exp_seed1));
      if (after_ab) break;
      bus.start    = poke && (c == 2 || c == c_done);
      bus.abort    = (c == ab_c) || (ab_c == 0 && poke && c == c_done);
      bus.comp_out = fixed ? val : 10'($urandom);
      if (c >= c_rs && c <= c_re && (ab_c == 0 || c <= ab_c)) samples.push_back(bus.comp_out);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.seed0   = 16'h1111;
    bus.seed1   = 16'h2222;
    bus.run_len = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (P + 3) begin
      bus.comp_out = 10'($urandom);
      @(negedge clk);
    end
    check("midrun_busy", 64'(bus.busy), 64'(1));
    resetn = 1'b0;
    #1;
    check_reset_vals("midrun_rst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("midrun_release_dut_resetn", 64'(bus.dut_resetn), 64'(1));
    exp_seed0 = 16'hACE1;
    exp_seed1 = 16'hACE1;
    exp_aborted = 1'b0;
    samples.delete();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.seed0    = '0;
    bus.seed1    = '0;
    bus.run_len  = '0;
    bus.comp_out = '0;
    #2 resetn = 1'b0;
    #10;
    check_reset_vals("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("release_dut_resetn", 64'(bus.dut_resetn), 64'(1));

    do_run(16'h0001, 16'h0002, 0, 0, 1'b0, 1'b1, 10'h0);
    check("len0_signature", 64'(bus.signature), 64'(0));
    do_run(16'h0003, 16'h0004, 2, 0, 1'b0, 1'b1, 10'h1);
    check("two_ones_signature", 64'(bus.signature), 64'(32'h3));
    do_run(16'h0005, 16'h0006, 1, 0, 1'b0, 1'b1, 10'h3FF);
    check("all_ones_signature", 64'(bus.signature), 64'(32'h3FF));
    do_run(16'h0007, 16'h0008, 33, 0, 1'b0, 1'b1, 10'h1);
    do_run(16'h0000, 16'h1234, 3, 0, 1'b0, 1'b0, 10'h0);
    do_run(16'h0009, 16'h0009, 10, P + 4, 1'b0, 1'b0, 10'h0);
    check("abort_sample_cnt", 64'(bus.sample_cnt), 64'(3));
    do_run(16'h00AA, 16'h0055, 5, 0, 1'b1, 1'b0, 10'h0);
    reset_mid_run();

    for (int i = 0; i < 30; i++) begin
      int len, ab;
      logic [15:0] s0, s1;
      len = $urandom_range(0, 40);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, P + 1 + len) : 0;
      s0  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      s1  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      do_run(s0, s1, len, ab, 1'($urandom_range(0, 1)), 1'b0, 10'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
